// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b mod 2^WIDTH.
// Operands are loaded in parallel and processed LSB first through one full
// subtractor with a registered borrow. One operation takes WIDTH+2 cycles
// including the DONE cycle.
// Optional build macro: SERIAL_SUB_SIGNED_OVF_EN adds signed overflow detection
// on the ovf output. Without it, ovf is tied to 0 and no overflow logic exists.

// Single-bit full subtractor: x - y - bin.
module serial_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d, bout;
    logic [WIDTH-1:0] r_next;

    serial_sub_bit u_bit (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    // Result register contents after the current bit is shifted in.
    assign r_next = {d, sr[WIDTH-1:1]};

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // On the last bit sa[0]/sb[0] are the operand sign bits: overflow when the
    // operand signs differ and the result sign differs from the minuend's.
    logic ovf_next;
    assign ovf_next = (sa[0] ^ sb[0]) & (d ^ sa[0]);

    // Overflow flag updates only on the completion edge, like diff.
    always_ff @(posedge clock) begin
        if (rst)
            ovf <= 1'b0;
        else if (state == SHIFT && cnt == LAST)
            ovf <= ovf_next;
    end
`else
    assign ovf = 1'b0;
`endif

    // Control FSM plus serial datapath; all outputs registered.
    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        sr    <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    sr  <= r_next;
                    br  <= bout;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        diff   <= r_next;
                        borrow <= bout;
                        zero   <= (r_next == '0);
                    end
                end
                DONE: begin
                    // start is not looked at here; no queuing of requests.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow, zero, ovf;
    logic [W-1:0] diff;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    int           tests = 0, fails = 0;
    int           ndone = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] last_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clock (clock), .rst (rst), .start (start), .a (a), .b (b),
        .busy (busy), .done (done), .diff (diff), .borrow (borrow),
        .zero (zero), .ovf (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        int   s;
        r.diff   = W'(int'(x) - int'(y));
        r.borrow = (x < y);
        r.zero   = (x == y);
        s = int'($signed(x)) - int'($signed(y));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        r.ovf = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
`else
        r.ovf = 1'b0;
`endif
        return r;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            ndone <= ndone + 1;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("diff", diff, e.diff);
                chk("borrow", borrow, e.borrow);
                chk("zero", zero, e.zero);
                chk("ovf", ovf, e.ovf);
            end
            chk("done_one_cycle", prev_done, 0);
        end
        prev_done <= done;
    end

    // One full operation from IDLE, checking latency, held outputs and busy.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        int k;
        bit held;
        exp_t x;
        @(negedge clock);
        start = 1'b1; a = ta; b = tb_;
        @(posedge clock);
        x = model(ta, tb_);
        exp_q.push_back(x);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        k = 0; held = 1'b1;
        while (done !== 1'b1 && k < W + 4) begin
            if (diff !== last_diff) held = 1'b0;
            @(negedge clock);
            k++;
        end
        chk("done_latency", k, W);
        chk("diff_held", held, 1);
        last_diff = x.diff;
        @(negedge clock);
        chk("busy_dropped", {busy, done}, 0);
    endtask

    initial begin
        int n0, k;
        int dl[$];
        exp_t x;

        repeat (3) @(negedge clock);
        chk("rst_outs", {busy, done, diff, borrow, zero, ovf}, 0);
        rst = 1'b0;

        // Directed cases
        do_op(8'd100, 8'd58);
        do_op(8'h3C, 8'h3C);
        do_op(8'h05, 8'h07);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);
        do_op(8'h00, 8'h00);

        // Reset mid-operation: no done, outputs zeroed
        n0 = ndone;
        @(negedge clock); start = 1'b1; a = 8'hF0; b = 8'h0F;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        chk("abort_outs", {busy, done, diff, borrow, zero, ovf}, 0);
        repeat (W + 4) @(negedge clock);
        chk("abort_no_done", ndone, n0);
        last_diff = '0;

        // Start during busy is ignored
        n0 = ndone;
        @(negedge clock); start = 1'b1; a = 8'h33; b = 8'h11;
        @(posedge clock);
        x = model(8'h33, 8'h11);
        exp_q.push_back(x);
        @(negedge clock); start = 1'b0;
        repeat (3) @(negedge clock);
        start = 1'b1; a = 8'hFF; b = 8'h01;
        @(negedge clock); start = 1'b0;
        repeat (W + 8) @(negedge clock);
        chk("ignored_start_one_done", ndone, n0 + 1);
        last_diff = x.diff;

        // Start held high: one op every W+2 cycles
        x = model(8'hC8, 8'h37);
        repeat (3) exp_q.push_back(x);
        @(negedge clock); start = 1'b1; a = 8'hC8; b = 8'h37;
        for (k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 29) start = 1'b0;
            if (done === 1'b1) dl.push_back(k);
        end
        chk("held_done_count", dl.size(), 3);
        if (dl.size() == 3) begin
            chk("held_done0", dl[0], W);
            chk("held_done1", dl[1], 2 * W + 2);
            chk("held_done2", dl[2], 3 * W + 4);
        end
        last_diff = x.diff;

        // Random operations
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor, the inverse-operation companion to the team's serial adder datapath. It loads two WIDTH-bit operands in parallel, computes a − b one bit per clock, LSB first, through a single-bit full subtractor and a registered borrow. It presents a registered parallel result with borrow and zero flags. A start/busy/done handshake lets a controller sequence operations without tracking cycle counts.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2–32.
- clock  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  minuend; sampled on the edge that accepts start.
- b  in  WIDTH  subtrahend; sampled on the edge that accepts start.
- busy  out  1  high in SHIFT and DONE states.
- done  out  1  one-cycle pulse; result valid.
- diff  out  WIDTH  registered result a − b mod 2^WIDTH.
- borrow  out  1  final borrow out of MSB (unsigned a < b).
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow; see Configuration.

## Operation
- Reset values: state IDLE; busy, done, diff, borrow, zero, ovf all 0; internal shift registers, borrow register and bit counter 0.
- Internal state: operand shift registers sa, sb; result shift register sr; borrow register br; bit counter cnt.
- FSM states are IDLE, SHIFT and DONE.
- IDLE → SHIFT when start=1:
  - sa←a, sb←b, sr←0, br←0, cnt←0.
  - start=0 holds IDLE.
- SHIFT, each edge:
  - d = sa[0]^sb[0]^br.
  - bout = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sr←{d, sr[WIDTH-1:1]}; sa, sb shift right with 0 fill; br←bout; cnt←cnt+1.
- SHIFT exit, on the edge where cnt==WIDTH-1:
  - Go to DONE.
  - diff←{d, sr[WIDTH-1:1]}; borrow←bout; zero←(that value == 0).
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
- diff, borrow, zero and ovf hold the previous result throughout an operation and change only on the completion edge.
- start is ignored in SHIFT and DONE; no queuing.
- Arithmetic is modulo 2^WIDTH. borrow=1 iff unsigned a < b.

## Timing
- Let edge 0 be the edge that accepts start.
- busy is high from after edge 0 through the cycle after edge WIDTH+1's preceding edge; it drops at edge WIDTH+1.
- Outputs update at edge WIDTH; done is high in the cycle between edges WIDTH and WIDTH+1.
- Earliest next acceptance is edge WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles when start is held high.
- rst during SHIFT or DONE returns to IDLE at that edge, zeroes all outputs, and produces no done pulse.
- rst and start in the same cycle: rst wins.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_SUB_SIGNED_OVF_EN defined:
  - On the completion edge, ovf←(sa[0]^sb[0]) & (d^sa[0]), evaluated with the MSB operand bits.
  - ovf=1 iff signed a − b is not representable in WIDTH bits.
  - ovf updates and holds like diff.
- Not defined: ovf is a constant 0 and the overflow logic is absent. The port remains so the interface is identical in both builds.

## Test plan
- WIDTH=8, a=100, b=58, start pulsed once → busy rises after edge 0; at edge 8 diff=0x2A, borrow=0, zero=0; done high exactly one cycle; busy low after edge 9.
- a=0x3C, b=0x3C → diff=0x00, zero=1, borrow=0.
- a=0x05, b=0x07 → diff=0xFE, borrow=1, zero=0; the previous diff value is held until edge 8.
- a=0x80, b=0x01 → diff=0x7F, borrow=0; ovf=1 with SERIAL_SUB_SIGNED_OVF_EN defined, ovf=0 without it.
- Start a=0xF0, b=0x0F, then rst=1 at edge 4 → all outputs 0 on the next cycle, no done pulse. A start pulse during a separate busy operation is ignored and the result is unaffected.
- start held high for 30 cycles with fixed operands → done pulses exactly every 10 cycles and diff stays correct.
